// File: rtl/snes_pad_pkg.sv
// Shared constants for the SNES pad CPU port: register map, button bit
// positions within the scanner vector, and CTRL register bit positions.
package snes_pad_pkg;

  // Register addresses on the CPU bus
  localparam logic [1:0] REG_SERIAL = 2'd0;
  localparam logic [1:0] REG_LO     = 2'd1;
  localparam logic [1:0] REG_HI     = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // Button bit indices in the scanner vector (1 = pressed)
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DN     = 5;
  localparam int BTN_LT     = 6;
  localparam int BTN_RT     = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam int NUM_BTN = 12;
  localparam int SHIFT_W = 16;

  // CTRL register bit positions
  localparam int CTRL_IEN  = 0;
  localparam int CTRL_PEND = 7;

  // Serial frame as the console sees it: buttons first (B at bit 0),
  // then the 4-bit controller signature.
  function automatic logic [SHIFT_W-1:0] serial_frame(input logic [3:0]         pad_id,
                                                      input logic [NUM_BTN-1:0] btn);
    return {pad_id, btn};
  endfunction

endpackage

// File: rtl/snes_pad_shifter.sv
// 16-bit parallel-load / serial-shift register behind the console-style
// serial read port. Load has priority over shift; the fill bit enters at
// the MSB so that reads past the end of the frame return a constant.
module snes_pad_shifter
  import snes_pad_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic               fill_i,
  input  logic [SHIFT_W-1:0] load_val_i,
  output logic               bit0_o
);

  logic [SHIFT_W-1:0] shift_q;
  logic [SHIFT_W-1:0] shift_d;

  // Next value: reload while strobe is high, otherwise shift on a read
  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = load_val_i;
    end else if (shift_i) begin
      shift_d = {fill_i, shift_q[SHIFT_W-1:1]};
    end
  end

  // Shift register state; resets to all ones (idle line level)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_q <= '1;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign bit0_o = shift_q[0];

endmodule

// File: rtl/snes_pad_port.sv
// CPU-facing register block for the SNES pad scanner output. Offers a
// console-style serial read port, coherent low/high snapshot registers and
// a button-change interrupt. The scanner updates `buttons` independently of
// CPU reads, so the high nibble is captured when the low byte is read.
module snes_pad_port
  import snes_pad_pkg::*;
#(
  parameter logic [3:0] PAD_ID   = 4'b0000,
  parameter logic       FILL_BIT = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_BTN-1:0] buttons,
  input  logic               cpu_cs,
  input  logic               cpu_rd,
  input  logic               cpu_we,
  input  logic [1:0]         cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               irq
);

  logic [7:0]         rdata_q,   rdata_d;
  logic               irq_q,     irq_d;
  logic               strobe_q,  strobe_d;
  logic [NUM_BTN-1:0] prev_q;
  logic [3:0]         hold_hi_q, hold_hi_d;
  logic               pending_q, pending_d;
  logic               ien_q,     ien_d;

  logic wr_acc;
  logic rd_acc;
  logic shift_en;
  logic shift_bit0;
  logic btn_changed;
  logic w1c_clear;

  // Only wdata[0] and wdata[7] carry meaning in this register map
  logic unused_wdata;
  assign unused_wdata = ^cpu_wdata[6:1];

  // A write wins over a simultaneous read: the read is dropped entirely
  assign wr_acc = cpu_cs & cpu_we;
  assign rd_acc = cpu_cs & cpu_rd & ~cpu_we;

  // Serial reads only advance the frame once strobe has been released
  assign shift_en = rd_acc & (cpu_addr == REG_SERIAL) & ~strobe_q;

  assign btn_changed = (buttons != prev_q);
  assign w1c_clear   = wr_acc & (cpu_addr == REG_CTRL) & cpu_wdata[CTRL_PEND];

  snes_pad_shifter u_shifter (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (strobe_q),
    .shift_i    (shift_en),
    .fill_i     (FILL_BIT),
    .load_val_i (serial_frame(PAD_ID, buttons)),
    .bit0_o     (shift_bit0)
  );

  // Read data mux and the addr1 snapshot side effect
  always_comb begin
    rdata_d   = rdata_q;
    hold_hi_d = hold_hi_q;
    if (rd_acc) begin
      case (cpu_addr)
        REG_SERIAL: begin
          // While strobed the register is transparent, so return the live B bit
          rdata_d = {7'b0, (strobe_q ? buttons[BTN_B] : shift_bit0)};
        end
        REG_LO: begin
          rdata_d   = buttons[7:0];
          hold_hi_d = buttons[NUM_BTN-1:8];
        end
        REG_HI: begin
          rdata_d = {pending_q, 3'b0, hold_hi_q};
        end
        default: begin
          rdata_d = {pending_q, 6'b0, ien_q};
        end
      endcase
    end
  end

  // Write decode for strobe and interrupt enable; addr1/addr2 writes are ignored
  always_comb begin
    strobe_d = strobe_q;
    ien_d    = ien_q;
    if (wr_acc) begin
      case (cpu_addr)
        REG_SERIAL: strobe_d = cpu_wdata[0];
        REG_CTRL:   ien_d    = cpu_wdata[CTRL_IEN];
        default:    ;
      endcase
    end
  end

  // Pending flag: a button change in the same cycle as a W1C keeps it set
  always_comb begin
    pending_d = pending_q;
    if (btn_changed) begin
      pending_d = 1'b1;
    end else if (w1c_clear) begin
      pending_d = 1'b0;
    end
    irq_d = pending_q & ien_q;
  end

  // Register state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q   <= 8'h00;
      irq_q     <= 1'b0;
      strobe_q  <= 1'b0;
      prev_q    <= '0;
      hold_hi_q <= 4'h0;
      pending_q <= 1'b0;
      ien_q     <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      strobe_q  <= strobe_d;
      prev_q    <= buttons;
      hold_hi_q <= hold_hi_d;
      pending_q <= pending_d;
      ien_q     <= ien_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_snes_pad_port.sv
// Directed bench for snes_pad_port: a vector table for the serial order and
// snapshot registers, plus hand-written sequences for strobe, interrupt,
// collision and mid-access reset behaviour.
module tb_snes_pad_port;

  logic        clk = 1'b0;
  logic        resetn;
  logic [11:0] buttons;
  logic        cpu_cs, cpu_rd, cpu_we;
  logic [1:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        rd;
    logic        we;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic [11:0] btn;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];

  snes_pad_port #(.PAD_ID(4'b0000), .FILL_BIT(1'b1)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .buttons   (buttons),
    .cpu_cs    (cpu_cs),
    .cpu_rd    (cpu_rd),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One-cycle bus access; returns on the falling edge after the access edge
  task automatic access(input logic rd, input logic we, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_cs = 1'b1; cpu_rd = rd; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    cpu_cs = 1'b0; cpu_rd = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic add_vec(input logic rd, input logic we, input logic [1:0] a, input logic [7:0] d,
                         input logic [11:0] btn, input logic chk, input logic [7:0] exp);
    vec_t v;
    v.rd = rd; v.we = we; v.addr = a; v.wdata = d; v.btn = btn; v.chk = chk; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    logic [16:0] ser_exp;
    ser_exp = 17'h10801;

    resetn = 1'b0; buttons = 12'h000;
    cpu_cs = 1'b0; cpu_rd = 1'b0; cpu_we = 1'b0; cpu_addr = 2'd0; cpu_wdata = 8'h00;

    // ---- vector table ----
    add_vec(1'b0, 1'b1, 2'd0, 8'h01, 12'h801, 1'b0, 8'h00);
    add_vec(1'b0, 1'b1, 2'd0, 8'h00, 12'h801, 1'b0, 8'h00);
    for (int i = 0; i < 17; i++)
      add_vec(1'b1, 1'b0, 2'd0, 8'h00, 12'h801, 1'b1, {7'b0, ser_exp[i]});
    add_vec(1'b1, 1'b0, 2'd1, 8'h00, 12'hA5C, 1'b1, 8'h5C);
    add_vec(1'b1, 1'b0, 2'd2, 8'h00, 12'h3FF, 1'b1, 8'h8A);
    add_vec(1'b0, 1'b1, 2'd1, 8'hFF, 12'h3FF, 1'b0, 8'h00);
    add_vec(1'b0, 1'b1, 2'd2, 8'hFF, 12'h3FF, 1'b0, 8'h00);
    add_vec(1'b1, 1'b0, 2'd2, 8'h00, 12'h3FF, 1'b1, 8'h8A);
    add_vec(1'b1, 1'b0, 2'd3, 8'h00, 12'h3FF, 1'b1, 8'h80);

    // ---- reset state ----
    idle(3);
    check("reset_rdata", cpu_rdata, 8'h00);
    check("reset_irq", {7'b0, irq}, 8'h00);
    resetn = 1'b1;
    idle(2);
    access(1'b1, 1'b0, 2'd3, 8'h00);
    check("reset_ctrl", cpu_rdata, 8'h00);

    // ---- table-driven vectors ----
    foreach (vecs[i]) begin
      @(negedge clk);
      buttons = vecs[i].btn;
      access(vecs[i].rd, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk) check($sformatf("vec[%0d]", i), cpu_rdata, vecs[i].exp);
    end

    // ---- strobe held: reads follow live B without shifting ----
    buttons = 12'h000;
    access(1'b0, 1'b1, 2'd0, 8'h01);
    idle(2);
    access(1'b1, 1'b0, 2'd0, 8'h00);
    check("strobe_b0", cpu_rdata, 8'h00);
    buttons = 12'h001;
    idle(2);
    access(1'b1, 1'b0, 2'd0, 8'h00);
    check("strobe_b1", cpu_rdata, 8'h01);
    buttons = 12'h000;
    idle(2);
    access(1'b1, 1'b0, 2'd0, 8'h00);
    check("strobe_b2", cpu_rdata, 8'h00);
    buttons = 12'h001;
    idle(2);
    access(1'b0, 1'b1, 2'd0, 8'h00);
    access(1'b1, 1'b0, 2'd0, 8'h00);
    check("strobe_fall_B", cpu_rdata, 8'h01);
    access(1'b1, 1'b0, 2'd0, 8'h00);
    check("strobe_fall_Y", cpu_rdata, 8'h00);

    // ---- interrupt ----
    access(1'b0, 1'b1, 2'd3, 8'h80);
    idle(1);
    check("irq_off", {7'b0, irq}, 8'h00);
    access(1'b0, 1'b1, 2'd3, 8'h01);
    access(1'b1, 1'b0, 2'd3, 8'h00);
    check("ctrl_ien_only", cpu_rdata, 8'h01);
    @(negedge clk);
    buttons = 12'h002;
    idle(1);
    check("irq_lat1", {7'b0, irq}, 8'h00);
    idle(1);
    check("irq_lat2", {7'b0, irq}, 8'h01);
    access(1'b1, 1'b0, 2'd3, 8'h00);
    check("ctrl_pend", cpu_rdata, 8'h81);
    access(1'b0, 1'b1, 2'd3, 8'h81);
    idle(1);
    check("irq_cleared", {7'b0, irq}, 8'h00);
    access(1'b1, 1'b0, 2'd3, 8'h00);
    check("ctrl_after_w1c", cpu_rdata, 8'h01);

    // ---- collision: button change with W1C ----
    @(negedge clk);
    buttons = 12'h004;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_rd = 1'b0; cpu_addr = 2'd3; cpu_wdata = 8'h81;
    @(negedge clk);
    cpu_cs = 1'b0; cpu_we = 1'b0;
    access(1'b1, 1'b0, 2'd3, 8'h00);
    check("set_wins", cpu_rdata, 8'h81);
    check("set_wins_irq", {7'b0, irq}, 8'h01);

    // ---- collision: rd+we on addr0 ----
    buttons = 12'h005;
    access(1'b0, 1'b1, 2'd0, 8'h01);
    idle(1);
    access(1'b0, 1'b1, 2'd0, 8'h00);
    access(1'b1, 1'b0, 2'd0, 8'h00);
    check("col_setup_B", cpu_rdata, 8'h01);
    access(1'b1, 1'b1, 2'd0, 8'h00);
    check("col_rdata_hold", cpu_rdata, 8'h01);
    access(1'b1, 1'b0, 2'd0, 8'h00);
    check("col_no_shift_Y", cpu_rdata, 8'h00);
    access(1'b1, 1'b0, 2'd0, 8'h00);
    check("col_SEL", cpu_rdata, 8'h01);
    @(negedge clk);
    buttons = 12'h000;
    access(1'b1, 1'b1, 2'd0, 8'h01);
    check("col2_rdata_hold", cpu_rdata, 8'h01);
    idle(2);
    access(1'b1, 1'b0, 2'd0, 8'h00);
    check("col2_live_b0", cpu_rdata, 8'h00);
    buttons = 12'h001;
    idle(2);
    access(1'b1, 1'b0, 2'd0, 8'h00);
    check("col2_live_b1", cpu_rdata, 8'h01);
    access(1'b0, 1'b1, 2'd0, 8'h00);

    // ---- reset in the middle of an access ----
    @(negedge clk);
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_addr = 2'd3;
    #2 resetn = 1'b0;
    buttons = 12'h000;
    @(posedge clk);
    #1;
    check("midrst_rdata", cpu_rdata, 8'h00);
    check("midrst_irq", {7'b0, irq}, 8'h00);
    @(negedge clk);
    cpu_cs = 1'b0; cpu_rd = 1'b0;
    resetn = 1'b1;
    idle(1);
    access(1'b1, 1'b0, 2'd3, 8'h00);
    check("midrst_ctrl", cpu_rdata, 8'h00);
    for (int i = 0; i < 17; i++) begin
      access(1'b1, 1'b0, 2'd0, 8'h00);
      check($sformatf("fill[%0d]", i), cpu_rdata, 8'h01);
    end
    check("midrst_irq_end", {7'b0, irq}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
